// File: rtl/fifo_led_async_pkg.sv
// Shared defaults and helpers for the LED/backlight word FIFO.
package fifo_led_async_pkg;

    localparam int unsigned DATA_WIDTH_DEF   = 24;
    localparam int unsigned DEPTH_WIDTH_DEF  = 12;
    localparam int unsigned DEPTH_DEF        = 32'd1 << DEPTH_WIDTH_DEF;
    localparam int unsigned ALMOST_FULL_DEF  = 1020;
    localparam int unsigned ALMOST_EMPTY_DEF = 4;

    // Occupancy widened to a plain integer so flag thresholds compare without width games.
    typedef int unsigned occ_t;

    // Flow-control flags, all decoded from the registered occupancy count.
    typedef struct packed {
        logic full;
        logic almost_full;
        logic empty;
        logic almost_empty;
    } fifo_flags_t;

    function automatic fifo_flags_t decode_flags(
        input occ_t occ,
        input occ_t depth,
        input occ_t almost_full_num,
        input occ_t almost_empty_num
    );
        fifo_flags_t f;
        f.full         = (occ == depth);
        f.almost_full  = (occ >= almost_full_num);
        f.empty        = (occ == 0);
        f.almost_empty = (occ <= almost_empty_num);
        return f;
    endfunction

endpackage

// File: rtl/fifo_led_async_if.sv
// Write/read handshake bundle between the dimming calculator and the LED formatter.
interface fifo_led_async_if
    import fifo_led_async_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) ();

    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_en;
    logic                  wr_full;
    logic                  almost_full;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_empty;
    logic                  almost_empty;

    // Producer/consumer side: issues requests and watches the flags.
    modport master (
        output wr_data,
        output wr_en,
        output rd_en,
        input  wr_full,
        input  almost_full,
        input  rd_data,
        input  rd_empty,
        input  almost_empty
    );

    // FIFO side: accepts requests and reports occupancy.
    modport slave (
        input  wr_data,
        input  wr_en,
        input  rd_en,
        output wr_full,
        output almost_full,
        output rd_data,
        output rd_empty,
        output almost_empty
    );

endinterface

// File: rtl/fifo_led_ram.sv
// Simple dual-port storage: one write port, one registered read port.
module fifo_led_ram
    import fifo_led_async_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = DEPTH_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  tb_rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int unsigned DEPTH = 32'd1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    // Store the incoming word at the write address.
    // NOTE: the array has no reset so it maps onto block RAM; stale words are
    // unreachable because the pointers and count are what get cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            // NOTE: non-blocking so every register updates from pre-edge values.
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read word: loads only on an accepted read, otherwise holds.
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fifo_led_async.sv
// Single-clock FIFO for 24-bit LED zone words with full/empty/almost flags.
module fifo_led_async
    import fifo_led_async_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = DATA_WIDTH_DEF,
    parameter int unsigned DEPTH_WIDTH      = DEPTH_WIDTH_DEF,
    parameter int unsigned ALMOST_FULL_NUM  = ALMOST_FULL_DEF,
    parameter int unsigned ALMOST_EMPTY_NUM = ALMOST_EMPTY_DEF
) (
    input  logic              clk,
    input  logic              tb_rst,
    fifo_led_async_if.slave   bus
);

    localparam int unsigned DEPTH = 32'd1 << DEPTH_WIDTH;

    // Pointers carry one extra wrap bit; the RAM address is the low bits.
    logic [DEPTH_WIDTH:0]   wr_ptr;
    logic [DEPTH_WIDTH:0]   rd_ptr;
    logic [DEPTH_WIDTH:0]   count;
    logic [DEPTH_WIDTH:0]   count_next;
    logic                   wr_accept;
    logic                   rd_accept;
    logic [DATA_WIDTH-1:0]  rd_word;
    fifo_flags_t            flags;

    // Flags are pure decodes of the registered count, so they move with it.
    always_comb begin
        flags = decode_flags(occ_t'(count), DEPTH, ALMOST_FULL_NUM, ALMOST_EMPTY_NUM);
    end

    // Accept decisions look only at the pre-edge flags: a read in the same
    // cycle does not open room for a write into a full FIFO.
    assign wr_accept = bus.wr_en && !flags.full;
    assign rd_accept = bus.rd_en && !flags.empty;

    // Occupancy moves by one unless both sides are accepted together.
    always_comb begin
        // NOTE: default first so every path assigns count_next and no latch forms.
        count_next = count;
        case ({wr_accept, rd_accept})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Pointer and count state; reset drops all contents immediately.
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
        end
    end

    fifo_led_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (DEPTH_WIDTH)
    ) u_ram (
        .clk     (clk),
        .tb_rst  (tb_rst),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr[DEPTH_WIDTH-1:0]),
        .wr_data (bus.wr_data),
        .rd_en   (rd_accept),
        .rd_addr (rd_ptr[DEPTH_WIDTH-1:0]),
        .rd_data (rd_word)
    );

    assign bus.rd_data      = rd_word;
    assign bus.wr_full      = flags.full;
    assign bus.almost_full  = flags.almost_full;
    assign bus.rd_empty     = flags.empty;
    assign bus.almost_empty = flags.almost_empty;

endmodule

// File: tb/tb_fifo_led_async.sv
// Self-checking bench for fifo_led_async: queue model plus directed and random phases.
module tb_fifo_led_async;

    localparam int unsigned DW    = 24;
    localparam int unsigned AW    = 12;
    localparam int unsigned DEPTH = 4096;
    localparam int unsigned AF    = 1020;
    localparam int unsigned AE    = 4;

    logic clk    = 1'b0;
    logic tb_rst = 1'b1;

    fifo_led_async_if #(.DATA_WIDTH(DW)) bus ();

    fifo_led_async #(
        .DATA_WIDTH       (DW),
        .DEPTH_WIDTH      (AW),
        .ALMOST_FULL_NUM  (AF),
        .ALMOST_EMPTY_NUM (AE)
    ) dut (
        .clk    (clk),
        .tb_rst (tb_rst),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: the FIFO is a queue, rd_data the last word popped.
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] model_rd = '0;
    bit            check_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on each active edge, using the occupancy before the edge.
    always @(posedge clk) begin
        if (!tb_rst) begin : model_step
            bit do_w;
            bit do_r;
            do_w = bus.wr_en && (model_q.size() < DEPTH);
            do_r = bus.rd_en && (model_q.size() != 0);
            if (do_r) model_rd = model_q.pop_front();
            if (do_w) model_q.push_back(bus.wr_data);
        end
    end

    // Compare every output against the model on the inactive edge.
    always @(negedge clk) begin
        if (check_en && !tb_rst) begin : cmp
            int unsigned occ;
            occ = model_q.size();
            check("rd_data",      32'(bus.rd_data),      32'(model_rd));
            check("wr_full",      32'(bus.wr_full),      32'(occ == DEPTH));
            check("almost_full",  32'(bus.almost_full),  32'(occ >= AF));
            check("rd_empty",     32'(bus.rd_empty),     32'(occ == 0));
            check("almost_empty", 32'(bus.almost_empty), 32'(occ <= AE));
        end
    end

    task automatic step(input bit w, input bit r, input logic [DW-1:0] d);
        bus.wr_en   = w;
        bus.rd_en   = r;
        bus.wr_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_flags(input string tag);
        check({tag, "_rd_empty"},     32'(bus.rd_empty),     32'd1);
        check({tag, "_almost_empty"}, 32'(bus.almost_empty), 32'd1);
        check({tag, "_wr_full"},      32'(bus.wr_full),      32'd0);
        check({tag, "_almost_full"},  32'(bus.almost_full),  32'd0);
        check({tag, "_rd_data"},      32'(bus.rd_data),      32'd0);
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.wr_data = '0;
        tb_rst      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_flags("reset");
        tb_rst   = 1'b0;
        check_en = 1'b1;
        @(posedge clk);
        #1;

        // Fill: 4097 consecutive writes, data decrementing from 0xFFFFFF.
        for (int i = 0; i <= int'(DEPTH); i++) begin
            step(1'b1, 1'b0, DW'(32'hFFFFFF - i));
            if (i + 1 == 4)    check("fill4_almost_empty",    32'(bus.almost_empty), 32'd1);
            if (i + 1 == 5)    check("fill5_almost_empty",    32'(bus.almost_empty), 32'd0);
            if (i + 1 == 1019) check("fill1019_almost_full",  32'(bus.almost_full),  32'd0);
            if (i + 1 == 1020) check("fill1020_almost_full",  32'(bus.almost_full),  32'd1);
            if (i + 1 == 4095) check("fill4095_wr_full",      32'(bus.wr_full),      32'd0);
            if (i + 1 == 4096) check("fill4096_wr_full",      32'(bus.wr_full),      32'd1);
            if (i + 1 == 4097) begin
                check("fill4097_wr_full",   32'(bus.wr_full),      32'd1);
                check("fill4097_occupancy", 32'(model_q.size()),   32'd4096);
            end
        end

        // Drain: 4097 consecutive reads, words come back in write order.
        for (int i = 0; i <= int'(DEPTH); i++) begin
            step(1'b0, 1'b1, '0);
            if (i < int'(DEPTH)) check("drain_data", 32'(bus.rd_data), 32'hFFFFFF - i);
            if (i == 0)          check("drain1_wr_full",     32'(bus.wr_full),  32'd0);
            if (i == 4094)       check("drain4095_rd_empty", 32'(bus.rd_empty), 32'd0);
            if (i == 4095)       check("drain4096_rd_empty", 32'(bus.rd_empty), 32'd1);
            if (i == 4096)       check("drain_final_rd_data", 32'(bus.rd_data), 32'hFFF000);
        end

        // Read and write together while empty: write lands, read is ignored.
        step(1'b1, 1'b1, 24'h5A5A5A);
        check("rw_empty_rd_empty", 32'(bus.rd_empty), 32'd0);
        check("rw_empty_rd_data",  32'(bus.rd_data),  32'hFFF000);
        step(1'b0, 1'b1, '0);
        check("rw_empty_readback", 32'(bus.rd_data),  32'h5A5A5A);
        check("rw_empty_drained",  32'(bus.rd_empty), 32'd1);

        // Hold occupancy at 10 with simultaneous read and write for 100 cycles.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, DW'($urandom));
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 1'b1, DW'($urandom));
            check("occ10_almost_empty", 32'(bus.almost_empty), 32'd0);
            check("occ10_rd_empty",     32'(bus.rd_empty),     32'd0);
            check("occ10_almost_full",  32'(bus.almost_full),  32'd0);
        end
        check("occ10_occupancy", 32'(model_q.size()), 32'd10);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, '0);
        check("occ10_drained", 32'(bus.rd_empty), 32'd1);

        // Reset mid-fill at occupancy 2000: contents vanish at once.
        for (int i = 0; i < 2000; i++) step(1'b1, 1'b0, DW'($urandom));
        check("mid_almost_full", 32'(bus.almost_full), 32'd1);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        tb_rst    = 1'b1;
        model_q.delete();
        model_rd  = '0;
        #1;
        check_reset_flags("mid_reset");
        #2;
        tb_rst = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, 24'hC3C3C3);
        check("post_reset_not_empty", 32'(bus.rd_empty), 32'd0);
        step(1'b0, 1'b1, '0);
        check("post_reset_readback", 32'(bus.rd_data), 32'hC3C3C3);

        // Random traffic with varying write/read bias, checked every cycle by the model.
        for (int phase = 0; phase < 6; phase++) begin
            int unsigned wp;
            int unsigned rp;
            wp = (phase % 2 == 0) ? 80 : 30;
            rp = (phase % 2 == 0) ? 30 : 80;
            for (int i = 0; i < 500; i++) begin
                step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp, DW'($urandom));
            end
        end
        step(1'b0, 1'b0, '0);

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
